// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game-level sequencer for the Flappy-VGA pipe datapath.
// Drives the Start/Stop/Ack level handshake of the pipe datapath, paces
// pipe scrolling from frame ticks, forwards button presses as flap pulses,
// holds the game-over screen and tracks the session best score.
module flappy_game_ctrl #(
  parameter int SCROLL_DIV = 1,
  parameter int OVER_HOLD  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic [3:0] score,
  input  logic       q_initial,
  input  logic       q_count,
  input  logic       q_stop,
  output logic       start,
  output logic       stop,
  output logic       ack,
  output logic       scroll_en,
  output logic       flap,
  output logic       game_over,
  output logic [3:0] best_score,
  output logic [1:0] state_o
);

  localparam int DIV_W  = $clog2(SCROLL_DIV + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(OVER_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    OVER  = 2'b10,
    CLEAR = 2'b11
  } state_e;

  state_e            state_q;
  logic              start_q, stop_q, ack_q;
  logic              scroll_q, flap_q, over_q;
  logic [3:0]        best_q;
  logic [DIV_W-1:0]  div_q;
  logic [HOLD_W-1:0] hold_q;
  logic              sync1_q, sync2_q, sync3_q;

  logic              btn_edge_d;
  logic              stop_req_d;

  // Two-flop synchronizer for the raw button plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // A held button yields only one edge; win (score 15) ends the run like a crash
  assign btn_edge_d = sync2_q & ~sync3_q;
  assign stop_req_d = collision | (score == 4'hF);

  // Game sequencer: state, handshake requests, pulses, divider, hold counter, best score
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      ack_q    <= 1'b0;
      scroll_q <= 1'b0;
      flap_q   <= 1'b0;
      over_q   <= 1'b0;
      best_q   <= 4'd0;
      div_q    <= '0;
      hold_q   <= '0;
    end else begin
      flap_q   <= 1'b0;
      scroll_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_q && q_count) begin
            start_q <= 1'b0;
            state_q <= RUN;
          end else if (!start_q && btn_edge_d) begin
            start_q <= 1'b1;
            flap_q  <= 1'b1;
          end
        end
        RUN: begin
          if (btn_edge_d) flap_q <= 1'b1;
          if (frame_tick) begin
            if (div_q == DIV_LAST) begin
              div_q <= '0;
              // No scrolling once the run is ending, including this very cycle
              if (q_count && !stop_q && !stop_req_d && !q_stop) scroll_q <= 1'b1;
            end else begin
              div_q <= div_q + DIV_ONE;
            end
          end
          // q_stop ends the run whether we requested it or the datapath did
          if (q_stop) begin
            stop_q  <= 1'b0;
            state_q <= OVER;
            hold_q  <= HOLD_INIT;
            over_q  <= 1'b1;
            if (score > best_q) best_q <= score;
          end else if (stop_req_d) begin
            stop_q <= 1'b1;
          end
        end
        OVER: begin
          if (frame_tick && (hold_q != '0)) hold_q <= hold_q - HOLD_ONE;
          // Only presses seen with the counter already drained are accepted
          if (btn_edge_d && (hold_q == '0)) begin
            ack_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          div_q <= '0;
          if (q_initial) begin
            ack_q   <= 1'b0;
            over_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start      = start_q;
  assign stop       = stop_q;
  assign ack        = ack_q;
  assign scroll_en  = scroll_q;
  assign flap       = flap_q;
  assign game_over  = over_q;
  assign best_score = best_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed testbench for flappy_game_ctrl with SCROLL_DIV=2, OVER_HOLD=4.
// The pipe datapath acknowledgements (q_initial/q_count/q_stop) are driven by hand.
module tb_flappy_game_ctrl;

  logic       clk, reset, btn, frame_tick, collision;
  logic [3:0] score;
  logic       q_initial, q_count, q_stop;
  logic       start, stop, ack, scroll_en, flap, game_over;
  logic [3:0] best_score;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  flappy_game_ctrl #(.SCROLL_DIV(2), .OVER_HOLD(4)) dut (
    .clk(clk), .reset(reset), .btn(btn), .frame_tick(frame_tick),
    .collision(collision), .score(score), .q_initial(q_initial),
    .q_count(q_count), .q_stop(q_stop), .start(start), .stop(stop),
    .ack(ack), .scroll_en(scroll_en), .flap(flap), .game_over(game_over),
    .best_score(best_score), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter RUN: press, wait for start, answer with q_count
  task automatic go_run();
    btn = 1'b1;
    tick(); tick(); tick();
    btn = 1'b0;
    q_initial = 1'b0;
    q_count = 1'b1;
    tick();
  endtask

  // Leave OVER: drain the hold counter, press, answer ack with q_initial
  task automatic leave_over();
    q_count = 1'b0;
    q_stop = 1'b0;
    collision = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
    btn = 1'b1;
    tick(); tick(); tick();
    btn = 1'b0;
    q_initial = 1'b1;
    tick();
    q_initial = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; btn = 1'b0; frame_tick = 1'b0; collision = 1'b0; score = 4'd0;
    q_initial = 1'b1; q_count = 1'b0; q_stop = 1'b0;
    tick(); tick();
    n_checks++; if ({start, stop, ack, scroll_en, flap, game_over} !== 6'b0) begin n_fail++; $display("FAIL rst_ctrl_during: got %b expected 000000", {start, stop, ack, scroll_en, flap, game_over}); end
    n_checks++; if (best_score !== 4'd0) begin n_fail++; $display("FAIL rst_best_during: got %0d expected 0", best_score); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL rst_state_during: got %b expected 00", state_o); end
    reset = 1'b1;
    tick();
    n_checks++; if ({start, stop, ack, scroll_en, flap, game_over} !== 6'b0) begin n_fail++; $display("FAIL rst_ctrl_after: got %b expected 000000", {start, stop, ack, scroll_en, flap, game_over}); end
    n_checks++; if ({best_score, state_o} !== 6'b0) begin n_fail++; $display("FAIL rst_best_state_after: got %b expected 000000", {best_score, state_o}); end
  endtask

  task automatic test_start();
    int flaps = 0;
    btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (flap === 1'b1) flaps++;
      if (i == 1) begin
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_early: got %b expected 0", start); end
      end
      if (i == 2) begin
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL start_rise: got %b expected 1", start); end
        n_checks++; if (flap !== 1'b1) begin n_fail++; $display("FAIL flap_start: got %b expected 1", flap); end
      end
      if (i == 3) begin
        n_checks++; if ({start, state_o} !== 3'b100) begin n_fail++; $display("FAIL start_hold: got start,state %b expected 100", {start, state_o}); end
        q_initial = 1'b0;
        q_count = 1'b1;
      end
      if (i == 4) begin
        n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL run_enter: got %b expected 01", state_o); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL start_drop: got %b expected 0", start); end
      end
    end
    n_checks++; if (flaps != 1) begin n_fail++; $display("FAIL flap_count_held: got %0d expected 1", flaps); end
    btn = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_scroll();
    int pulses = 0;
    score = 4'd3;
    for (int k = 0; k < 6; k++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      if (scroll_en === 1'b1) pulses++;
      n_checks++; if (scroll_en !== ((k % 2) == 1)) begin n_fail++; $display("FAIL scroll_tick%0d: got %b expected %b", k, scroll_en, (k % 2) == 1); end
      tick();
      n_checks++; if (scroll_en !== 1'b0) begin n_fail++; $display("FAIL scroll_width%0d: got %b expected 0", k, scroll_en); end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL scroll_count: got %0d expected 3", pulses); end
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    n_checks++; if ({scroll_en, stop} !== 2'b00) begin n_fail++; $display("FAIL scroll_tick7: got scroll,stop %b expected 00", {scroll_en, stop}); end
    tick();
    frame_tick = 1'b1; collision = 1'b1; tick(); frame_tick = 1'b0;
    n_checks++; if (scroll_en !== 1'b0) begin n_fail++; $display("FAIL scroll_suppressed: got %b expected 0", scroll_en); end
    n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL stop_on_collision: got %b expected 1", stop); end
    q_count = 1'b0; q_stop = 1'b1; tick();
    n_checks++; if ({state_o, stop, game_over} !== 4'b1001) begin n_fail++; $display("FAIL over_enter1: got state,stop,go %b expected 1001", {state_o, stop, game_over}); end
    n_checks++; if (best_score !== 4'd3) begin n_fail++; $display("FAIL best_first: got %0d expected 3", best_score); end
    q_stop = 1'b0; collision = 1'b0;
  endtask

  task automatic test_over_hold();
    for (int i = 0; i < 2; i++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    end
    btn = 1'b1; tick(); tick(); tick();
    n_checks++; if ({ack, state_o} !== 3'b010) begin n_fail++; $display("FAIL hold_ignore_early: got ack,state %b expected 010", {ack, state_o}); end
    btn = 1'b0; tick(); tick(); tick();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    // Press whose edge coincides with the 4th tick
    btn = 1'b1; tick(); tick();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    n_checks++; if ({ack, state_o} !== 3'b010) begin n_fail++; $display("FAIL hold_ignore_same: got ack,state %b expected 010", {ack, state_o}); end
    btn = 1'b0; tick(); tick(); tick();
    btn = 1'b1; tick(); tick(); tick();
    n_checks++; if ({ack, state_o, game_over} !== 4'b1111) begin n_fail++; $display("FAIL clear_enter: got ack,state,go %b expected 1111", {ack, state_o, game_over}); end
    btn = 1'b0; tick();
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_hold: got %b expected 1", ack); end
    q_initial = 1'b1; tick(); q_initial = 1'b0;
    n_checks++; if ({ack, state_o, game_over} !== 4'b0000) begin n_fail++; $display("FAIL idle_return: got ack,state,go %b expected 0000", {ack, state_o, game_over}); end
    tick(); tick();
  endtask

  task automatic test_best_score();
    go_run();
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL run_game2: got %b expected 01", state_o); end
    score = 4'd7; collision = 1'b1; tick();
    n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL stop_game2: got %b expected 1", stop); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if ({stop, state_o} !== 3'b101) begin n_fail++; $display("FAIL stop_hold%0d: got stop,state %b expected 101", i, {stop, state_o}); end
    end
    q_count = 1'b0; q_stop = 1'b1; tick();
    n_checks++; if ({state_o, stop, game_over} !== 4'b1001) begin n_fail++; $display("FAIL over_enter2: got %b expected 1001", {state_o, stop, game_over}); end
    n_checks++; if (best_score !== 4'd7) begin n_fail++; $display("FAIL best_update: got %0d expected 7", best_score); end
    leave_over();
  endtask

  task automatic test_back_to_back();
    go_run();
    score = 4'd5;
    btn = 1'b1; tick(); tick();
    collision = 1'b1; tick();
    n_checks++; if ({flap, stop} !== 2'b11) begin n_fail++; $display("FAIL flap_and_stop: got flap,stop %b expected 11", {flap, stop}); end
    btn = 1'b0; tick();
    n_checks++; if (flap !== 1'b0) begin n_fail++; $display("FAIL flap_width: got %b expected 0", flap); end
    q_count = 1'b0; q_stop = 1'b1; tick();
    n_checks++; if ({state_o, best_score} !== 6'b10_0111) begin n_fail++; $display("FAIL best_keep: got state,best %b expected 100111", {state_o, best_score}); end
    leave_over();
  endtask

  task automatic test_win_and_reset();
    go_run();
    score = 4'd15; tick();
    n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL stop_win: got %b expected 1", stop); end
    q_count = 1'b0; q_stop = 1'b1; tick();
    n_checks++; if ({state_o, best_score} !== 6'b10_1111) begin n_fail++; $display("FAIL best_win: got state,best %b expected 101111", {state_o, best_score}); end
    score = 4'd0;
    leave_over();
    go_run();
    score = 4'd2; tick();
    n_checks++; if ({stop, state_o} !== 3'b001) begin n_fail++; $display("FAIL run_no_stop: got stop,state %b expected 001", {stop, state_o}); end
    q_count = 1'b0; q_stop = 1'b1; tick();
    n_checks++; if ({state_o, stop, game_over} !== 4'b1001) begin n_fail++; $display("FAIL over_unsolicited: got %b expected 1001", {state_o, stop, game_over}); end
    q_stop = 1'b0;
    #2 reset = 1'b0; #1;
    n_checks++; if ({start, stop, ack, scroll_en, flap, game_over, best_score, state_o} !== 12'b0) begin n_fail++; $display("FAIL rst_midgame: got %b expected all zero", {start, stop, ack, scroll_en, flap, game_over, best_score, state_o}); end
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if ({game_over, best_score, state_o} !== 7'b0) begin n_fail++; $display("FAIL rst_release2: got %b expected 0000000", {game_over, best_score, state_o}); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_scroll();
    test_over_hold();
    test_best_score();
    test_back_to_back();
    test_win_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
